// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the HD44780-style bus responder.
//   Command prefixes are named by the highest set bit of the command byte,
//   so cmd_class() maps any command byte onto exactly one of them.
package lcd_pkg;

  localparam int          DDRAM_DEPTH = 128;
  localparam logic [7:0]  FILL_CHAR   = 8'h20;

  localparam logic [7:0]  CMD_NOP     = 8'h00;
  localparam logic [7:0]  CMD_CLEAR   = 8'h01;
  localparam logic [7:0]  CMD_HOME    = 8'h02;
  localparam logic [7:0]  CMD_ENTRY   = 8'h04;
  localparam logic [7:0]  CMD_DISPCTL = 8'h08;
  localparam logic [7:0]  CMD_SHIFT   = 8'h10;
  localparam logic [7:0]  CMD_FUNC    = 8'h20;
  localparam logic [7:0]  CMD_CGADDR  = 8'h40;
  localparam logic [7:0]  CMD_DDADDR  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_CLEAR
  } state_e;

  // One-hot of the highest set bit; 0 for the all-zero no-op byte.
  function automatic logic [7:0] cmd_class(input logic [7:0] b);
    cmd_class = CMD_NOP;
    for (int i = 0; i < 8; i++)
      if (b[i]) cmd_class = 8'h01 << i;
  endfunction

  // 7-bit modulo step used for both AC and display shift.
  function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
    step7 = up ? v + 7'd1 : v - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 128x8 display RAM.
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i -> rdata_o   : registered read (AC side)
//   maddr_i -> mdata_o   : registered read (monitor side)
//   Storage has no reset; only the read registers clear on rst_i.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [6:0] maddr_i,
  output logic [7:0] mdata_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] rd_q, mon_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_q  <= '0;
      mon_q <= '0;
    end else begin
      rd_q  <= mem_q[raddr_i];
      mon_q <= mem_q[maddr_i];
    end
  end

  assign rdata_o = rd_q;
  assign mdata_o = mon_q;

endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: display-side endpoint of the 8-bit parallel LCD bus.
//   clk, rst (sync, active high)
//   lcd_en/lcd_rs/lcd_rw/lcd_din : bus from controller, committed on en fall
//   lcd_dout/lcd_dout_oe         : read data returned to controller
//   busy, addr_cnt, mode flags, disp_shift, ovr_err : decoded display state
//   mon_addr -> mon_char         : 1-cycle monitor read of DDRAM
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe,
  output logic       busy,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic [6:0] disp_shift,
  output logic       ovr_err,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_char
);

  localparam int CW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    clr_q, ac_q, shift_q;
  logic          en_d_q, rs_q, rw_q, oe_q;
  logic [7:0]    din_q;
  logic          disp_q, cur_q, blink_q, two_q, inc_q, shm_q, ovr_q;

  logic          fall, busy_w, data_wr;
  logic          ram_we;
  logic [6:0]    ram_waddr;
  logic [7:0]    ram_wdata, ram_rdata;

  assign fall    = en_d_q & ~lcd_en;
  assign busy_w  = (state_q != ST_IDLE);
  assign data_wr = fall & rs_q & ~rw_q & ~busy_w;

  // Clear sweep and data writes never overlap: a data write is only
  // accepted in IDLE. rst gates the port so an aborted clear stops at once.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ac_q;
    ram_wdata = din_q;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        ram_wdata = FILL_CHAR;
      end else if (data_wr) begin
        ram_we    = 1'b1;
      end
    end
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ac_q),
    .rdata_o (ram_rdata),
    .maddr_i (mon_addr),
    .mdata_o (mon_char)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clr_q   <= '0;
      ac_q    <= '0;
      shift_q <= '0;
      en_d_q  <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      din_q   <= '0;
      oe_q    <= 1'b0;
      disp_q  <= 1'b0;
      cur_q   <= 1'b0;
      blink_q <= 1'b0;
      two_q   <= 1'b0;
      inc_q   <= 1'b1;
      shm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      en_d_q <= lcd_en;
      oe_q   <= lcd_en & lcd_rw;
      if (lcd_en) begin
        rs_q  <= lcd_rs;
        rw_q  <= lcd_rw;
        din_q <= lcd_din;
      end

      case (state_q)
        ST_BUSY: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        ST_CLEAR: begin
          clr_q <= clr_q + 7'd1;
          if (clr_q == 7'(DDRAM_DEPTH - 1)) begin
            state_q <= ST_IDLE;
            ac_q    <= '0;
            shift_q <= '0;
            inc_q   <= 1'b1;
          end
        end
        default: ;
      endcase

      // Commit. Status reads never touch state; everything else is
      // dropped while busy (reads silently, writes flag the overrun).
      if (fall && !(rw_q && !rs_q)) begin
        if (busy_w) begin
          if (!rw_q) ovr_q <= 1'b1;
        end else begin
          state_q <= ST_BUSY;
          cnt_q   <= CW'(BUSY_CYC - 1);
          if (rw_q) begin
            ac_q <= step7(ac_q, inc_q);
          end else if (rs_q) begin
            ac_q <= step7(ac_q, inc_q);
            if (shm_q) shift_q <= step7(shift_q, inc_q);
          end else begin
            case (cmd_class(din_q))
              CMD_DDADDR:  ac_q <= din_q[6:0];
              CMD_FUNC:    two_q <= din_q[3];
              CMD_SHIFT: begin
                if (din_q[3]) shift_q <= step7(shift_q, din_q[2]);
                else          ac_q    <= step7(ac_q, din_q[2]);
              end
              CMD_DISPCTL: {disp_q, cur_q, blink_q} <= din_q[2:0];
              CMD_ENTRY:   {inc_q, shm_q} <= din_q[1:0];
              CMD_HOME: begin
                ac_q    <= '0;
                shift_q <= '0;
              end
              CMD_CLEAR: begin
                state_q <= ST_CLEAR;
                clr_q   <= '0;
              end
              default: ; // CGRAM address and no-op: accepted, no state
            endcase
          end
        end
      end
    end
  end

  // Data read returns 0 while busy since that read will be ignored.
  always_comb begin
    lcd_dout = '0;
    if (oe_q) begin
      if (!rs_q)       lcd_dout = {busy_w, ac_q};
      else if (!busy_w) lcd_dout = ram_rdata;
    end
  end

  assign lcd_dout_oe = oe_q;
  assign busy        = busy_w;
  assign addr_cnt    = ac_q;
  assign disp_shift  = shift_q;
  assign disp_on     = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign two_line    = two_q;
  assign inc_mode    = inc_q;
  assign shift_mode  = shm_q;
  assign ovr_err     = ovr_q;

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Receiving end of the 8-bit HD44780-style parallel LCD bus driven by the team's `lcd` controller. It samples `en`/`rs`/`rw`/data in the system clock domain and commits a bus transaction on each falling edge of `en`. It decodes the command set, maintains the DDRAM, address counter, display/entry state and busy flag, and answers status and data reads. It serves both as a synthesizable display-side model and as the checker-facing endpoint in controller benches.

## Interface
- `BUSY_CYC`, default 4: busy duration in cycles for every transaction except clear.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `lcd_en` in 1: bus enable strobe.
- `lcd_rs` in 1: 0 = command/status, 1 = data.
- `lcd_rw` in 1: 0 = write, 1 = read.
- `lcd_din` in 8: bus data from controller.
- `lcd_dout` out 8: read data to controller.
- `lcd_dout_oe` out 1: high while a read drives the bus.
- `busy` out 1: busy flag.
- `addr_cnt` out 7: address counter (AC).
- `disp_on`, `cursor_on`, `blink_on`, `two_line`, `inc_mode`, `shift_mode` out 1 each: decoded mode state.
- `disp_shift` out 7: display shift offset.
- `ovr_err` out 1: sticky; a write was dropped because it arrived while busy.
- `mon_addr` in 7, `mon_char` out 8: monitor read port; `mon_char` = DDRAM[`mon_addr`] with a 1-cycle registered delay.

## Operation
- Capture: on every cycle with `lcd_en`=1, register `lcd_rs`, `lcd_rw` and `lcd_din`. `en_d` is `lcd_en` delayed one cycle. A falling edge is `en_d`=1 and `lcd_en`=0; it commits the captured values.
- Command write (rs=0, rw=0), decoded by the highest set bit of the captured byte:
  - `1aaaaaaa`: AC=a.
  - `01xxxxxx`: CGRAM address; accepted, no state change.
  - `001DNFxx`: `two_line`=N.
  - `0001SRxx`: S=0 moves AC by +1 (R=1) or -1 (R=0); S=1 moves `disp_shift` the same way.
  - `00001DCB`: sets `disp_on`, `cursor_on`, `blink_on`.
  - `000001IS`: sets `inc_mode`, `shift_mode`.
  - `0000001x`: AC=0, `disp_shift`=0.
  - `00000001`: clear.
  - `00000000`: no-op.
- Clear: FSM state CLEAR writes 0x20 to DDRAM[0..127], one address per cycle. Then AC=0, `disp_shift`=0, `inc_mode`=1.
- Data write (rs=1, rw=0): DDRAM[AC]=byte. AC advances by ±1 per `inc_mode`. If `shift_mode`=1, `disp_shift` also moves in the same direction.
- Status read (rs=0, rw=1): `lcd_dout`={busy, AC}. Allowed while busy. No state change.
- Data read (rs=1, rw=1): `lcd_dout`=DDRAM[AC]. AC advances on the falling edge. If busy, the read is ignored: `lcd_dout`=0, no AC change, `ovr_err` not set.
- Writes committed while `busy`=1 are dropped and set `ovr_err`. Only `rst` clears `ovr_err`.
- All AC and `disp_shift` arithmetic is 7-bit modulo 128: 127+1 wraps to 0, 0-1 wraps to 127.
- FSM states:
  - IDLE → BUSY after any accepted write, and after any accepted data read.
  - IDLE → CLEAR after a clear command.
  - BUSY → IDLE when the counter expires.
  - CLEAR → IDLE after address 127 is written.

## Timing
- Reset values:
  - `lcd_dout`=0, `lcd_dout_oe`=0, `busy`=0, `addr_cnt`=0, `disp_shift`=0, `ovr_err`=0, `mon_char`=0.
  - `disp_on`=`cursor_on`=`blink_on`=0, `two_line`=0, `inc_mode`=1, `shift_mode`=0.
  - FSM=IDLE. DDRAM contents are undefined.
- Falling edge detected in cycle N: state updates, DDRAM write and `busy`=1 are all visible from cycle N+1.
- `busy` lasts exactly `BUSY_CYC` cycles for normal transactions and exactly 128 cycles for clear.
- Read data: `lcd_dout_oe`=1 and `lcd_dout` are valid from the cycle after `lcd_en` is first sampled high. They hold until the cycle after `lcd_en` is sampled low, then `lcd_dout_oe`=0.
- A falling edge in the same cycle the busy counter expires counts as busy, so a write is dropped.
- `rst` asserted mid-clear or mid-busy aborts the operation immediately and applies reset values. DDRAM keeps the partially cleared contents.
- Minimum `en` pulse: 1 cycle high, 1 cycle low. Back-to-back pulses must each be committed.

## Structure
- Shared package `lcd_pkg` holds:
  - command prefix constants (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNC, CGADDR, DDADDR);
  - the fill constant 0x20;
  - the DDRAM depth 128;
  - the FSM state typedef (IDLE, BUSY, CLEAR).
- Sub-module `lcd_ddram`: 128×8 RAM with one synchronous write port, one registered read port for the AC read and one registered read port for the monitor.

## Test plan
- After reset, write commands 0x38, 0x01, 0x0E, 0x06, 0x80, each after `busy` falls → `two_line`=1; `busy` high 128 cycles after 0x01; all cells read 0x20; `disp_on`=1, `cursor_on`=1, `blink_on`=0; `inc_mode`=1; `addr_cnt`=0.
- Data writes 0x76, 0x65, 0x72, 0x69, 0x6C, 0x6F, 0x67 → `mon_char` at addresses 0–6 returns "verilog"; `addr_cnt`=7.
- Command 0xFF, then data write 0x41 → DDRAM[127]=0x41, `addr_cnt` wraps to 0. Entry mode 0x04, then one data write at AC=0 → `addr_cnt`=127.
- Write sent 1 cycle after a previous write's commit → dropped, `ovr_err`=1, DDRAM unchanged. A status read in that window returns bit 7=1.
- Command 0x85, then data read → `lcd_dout`=DDRAM[5] while `lcd_dout_oe`=1, `addr_cnt`=6 afterwards. Status read → 0x06.
- `rst` asserted 40 cycles into a clear → `busy`=0, FSM=IDLE next cycle; cells 0–38 read 0x20; other outputs at reset values.
